// File: rtl/shift_register_seq.sv
// Transmit sequencer for an 8-bit universal shift register: it accepts a word,
// parallel-loads it into the register, then shifts it out as a paced serial stream.
module shift_register_seq #(
   parameter int   WIDTH      = 8,
   parameter int   BIT_CYCLES = 1,
   parameter logic FILL       = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             msb_first,
   input  logic             abort,
   input  logic [WIDTH-1:0] sr_o,
   output logic [WIDTH-1:0] sr_i,
   output logic [1:0]       sr_s,
   output logic             sr_r,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

   // state  | meaning
   // S_IDLE | waiting for a word, in_ready high
   // S_LOAD | one cycle of parallel load into the register
   // S_BIT  | presenting bits, shifting on the last pace cycle of each bit
   // S_DONE | one-cycle completion pulse
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_DONE} state_t;

   localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int BW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             dir_q, dir_d;
   logic [PW-1:0]    pace_q, pace_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             last_pace;
   logic             unused_sr;

   assign last_pace = (pace_q == PW'(BIT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         dir_q   <= 1'b0;
         pace_q  <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         pace_q  <= pace_d;
         bit_q   <= bit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dir_d   = dir_q;
      pace_d  = pace_q;
      bit_d   = bit_q;
      sr_s    = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_LOAD;
               data_d  = in_data;
               dir_d   = msb_first;
               pace_d  = '0;
               bit_d   = '0;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               sr_s    = 2'b11;
               state_d = S_BIT;
            end
         end
         S_BIT: begin
            // abort also beats the shift on the final bit, so no done is issued
            if (abort) begin
               state_d = S_IDLE;
            end else if (last_pace) begin
               sr_s   = dir_q ? 2'b10 : 2'b01;
               pace_d = '0;
               bit_d  = bit_q + 1'b1;
               if (bit_q == BW'(WIDTH - 1)) begin
                  state_d = S_DONE;
               end
            end else begin
               pace_d = pace_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign ser_valid = (state_q == S_BIT);
   assign ser_out   = dir_q ? sr_o[WIDTH-1] : sr_o[0];
   assign sr_i      = data_q;
   assign sr_r      = FILL;
   assign unused_sr = ^sr_o[WIDTH-2:1];

endmodule

// File: tb/tb_shift_register_seq.sv
// Bench: two sequencers (1 and 3 clocks per bit), each driving a behavioural
// universal shift register, checked cycle by cycle against an arithmetic model.
module tb_shift_register_seq;

   logic       clk = 1'b0;
   logic [7:0] in_data   [2];
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic       msb_first [2];
   logic       abort     [2];
   logic       reset     [2];
   logic [7:0] sr_o      [2];
   logic [7:0] sr_i      [2];
   logic [1:0] sr_s      [2];
   logic       sr_r      [2];
   logic       ser_out   [2];
   logic       ser_valid [2];
   logic       busy      [2];
   logic       done      [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_acc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_unit
      shift_register_seq #(
         .WIDTH     (8),
         .BIT_CYCLES((g == 0) ? 1 : 3),
         .FILL      (1'b1)
      ) dut (
         .clk      (clk),
         .reset    (reset[g]),
         .in_data  (in_data[g]),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .msb_first(msb_first[g]),
         .abort    (abort[g]),
         .sr_o     (sr_o[g]),
         .sr_i     (sr_i[g]),
         .sr_s     (sr_s[g]),
         .sr_r     (sr_r[g]),
         .ser_out  (ser_out[g]),
         .ser_valid(ser_valid[g]),
         .busy     (busy[g]),
         .done     (done[g])
      );

      // the external universal shift register
      always @(posedge clk) begin
         case (sr_s[g])
            2'b01:   sr_o[g] <= {sr_r[g], sr_o[g][7:1]};
            2'b10:   sr_o[g] <= {sr_o[g][6:0], sr_r[g]};
            2'b11:   sr_o[g] <= sr_i[g];
            default: sr_o[g] <= sr_o[g];
         endcase
      end
   end

   function automatic int bc(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input int u, input string tag);
      chk({tag, "_ctl"}, {in_ready[u], busy[u], ser_valid[u], done[u], sr_s[u], sr_r[u]},
          {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1});
   endtask

   // kill_c: relative cycle at which to abort (kill_rst=0) or pull reset (kill_rst=1); -1 none
   task automatic xfer(input int u, input logic [7:0] w, input logic msb, input int kill_c,
                       input bit kill_rst, input bit keep_valid, input logic [7:0] w_next);
      int b;
      int nb;
      int sv_cnt;
      int k;
      logic [5:0] exp_v;
      logic       eb;
      b = bc(u);
      nb = 8 * b;
      sv_cnt = 0;
      in_data[u]   = w;
      msb_first[u] = msb;
      in_valid[u]  = 1'b1;
      for (k = 0; k < 60 && !in_ready[u]; k++) step();
      chk($sformatf("u%0d_accept_wait", u), {31'd0, in_ready[u]}, 32'd1);
      step();
      last_acc = cyc;
      if (keep_valid) in_data[u] = w_next;
      else in_valid[u] = 1'b0;
      msb_first[u] = 1'($urandom);
      for (int c = 0; c <= nb + 1; c++) begin
         if (c == kill_c) begin
            if (kill_rst) reset[u] = 1'b0;
            else abort[u] = 1'b1;
         end
         #1;
         // {ser_valid, sr_s, done, busy, in_ready} and the bit when valid
         if (c == 0) begin
            exp_v = {1'b0, 2'b11, 1'b0, 1'b1, 1'b0};
            eb = 1'b0;
            chk($sformatf("u%0d_sr_i", u), {24'd0, sr_i[u]}, {24'd0, w});
         end else if (c <= nb) begin
            eb = msb ? w[7 - (c - 1) / b] : w[(c - 1) / b];
            exp_v = {1'b1, ((c - 1) % b == b - 1) ? (msb ? 2'b10 : 2'b01) : 2'b00, 1'b0, 1'b1, 1'b0};
            sv_cnt++;
            if (c == 1) chk($sformatf("u%0d_loaded", u), {24'd0, sr_o[u]}, {24'd0, w});
         end else begin
            exp_v = {1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
            eb = 1'b0;
            chk($sformatf("u%0d_final_reg", u), {24'd0, sr_o[u]}, 32'hFF);
         end
         if (c == kill_c && !kill_rst) exp_v[4:3] = 2'b00;
         chk($sformatf("u%0d_c%0d", u, c),
             {ser_valid[u], sr_s[u], done[u], busy[u], in_ready[u], ser_valid[u] & ser_out[u]},
             {exp_v, eb});
         step();
         if (c == kill_c) begin
            abort[u] = 1'b0;
            reset[u] = 1'b1;
            chk_idle(u, $sformatf("u%0d_after_kill", u));
            if (kill_rst) begin
               chk($sformatf("u%0d_rst_sr_i", u), {24'd0, sr_i[u]}, 32'd0);
               chk($sformatf("u%0d_rst_ser_out", u), {31'd0, ser_out[u]}, {31'd0, sr_o[u][0]});
            end
            return;
         end
      end
      chk($sformatf("u%0d_sv_count", u), sv_cnt, nb);
      chk({$sformatf("u%0d_back_idle", u)}, {in_ready[u], busy[u], done[u]}, 3'b100);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      int t1;
      for (int u = 0; u < 2; u++) begin
         in_data[u] = 8'h00; in_valid[u] = 1'b0; msb_first[u] = 1'b0;
         abort[u] = 1'b0; reset[u] = 1'b0;
      end
      step();
      step();
      for (int u = 0; u < 2; u++) reset[u] = 1'b1;
      for (int u = 0; u < 2; u++) begin
         chk_idle(u, $sformatf("u%0d_reset", u));
         chk($sformatf("u%0d_reset_sr_i", u), {24'd0, sr_i[u]}, 32'd0);
         chk($sformatf("u%0d_reset_ser_out", u), {31'd0, ser_out[u]}, {31'd0, sr_o[u][0]});
      end

      xfer(0, 8'hB3, 1'b0, -1, 1'b0, 1'b0, 8'h00);
      xfer(0, 8'hB3, 1'b1, -1, 1'b0, 1'b0, 8'h00);
      xfer(1, 8'h01, 1'b0, -1, 1'b0, 1'b0, 8'h00);

      xfer(0, 8'hA5, 1'b0, -1, 1'b0, 1'b1, 8'h5A);
      t1 = last_acc;
      xfer(0, 8'h5A, 1'b0, -1, 1'b0, 1'b0, 8'h00);
      chk("accept_spacing", last_acc - t1, 32'd11);

      xfer(0, 8'hF0, 1'b0, 4, 1'b0, 1'b0, 8'h00);
      xfer(1, 8'hC7, 1'b1, 24, 1'b0, 1'b0, 8'h00);
      xfer(0, 8'h3C, 1'b0, 6, 1'b1, 1'b0, 8'h00);
      xfer(0, 8'h96, 1'b1, -1, 1'b0, 1'b0, 8'h00);

      for (int i = 0; i < 10; i++) begin
         xfer(i % 2, 8'($urandom), 1'($urandom), -1, 1'b0, 1'b0, 8'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
